// File: rtl/memory_responder.sv
// memory_responder: wait-state memory responder on the miniSRC MAR/MDR bus.
// Accepts one Read/Write from IDLE, services it after WAIT_STATES, pulses done.
module memory_responder #(
  parameter int    ADDR_W      = 9,
  parameter int    DATA_W      = 32,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       MAR_addr,
  input  logic [DATA_W-1:0] MDR_data,
  output logic [DATA_W-1:0] Mdatain,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] WS    = 4'(WAIT_STATES);
  localparam int         DEPTH = 1 << ADDR_W;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              accept;
  logic              reject;
  logic              commit;
  logic              wr_q;
  logic              oor_q;
  logic              rej_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              req_oor;
  logic              c_wr;
  logic              c_oor;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic [DATA_W-1:0] mem [DEPTH];

  assign req_oor = |(MAR_addr >> ADDR_W);

  // With zero wait states RESP is entered on the accept edge itself,
  // so the commit must use the live request rather than the latched copy.
  assign c_wr   = accept ? Write : wr_q;
  assign c_oor  = accept ? req_oor : oor_q;
  assign c_addr = accept ? MAR_addr[ADDR_W-1:0] : addr_q;
  assign c_data = accept ? MDR_data : data_q;

  // Next-state, wait countdown and status outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    reject   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Read && Write) begin
          reject = 1'b1;
        end else if (Read || Write) begin
          accept  = 1'b1;
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    commit   = (state_d == S_RESP) && (state_q != S_RESP);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_RESP);
    addr_err = (done && oor_q) || rej_q;
  end

  // State and wait counter.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch, reject flag and registered load data.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      rej_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      Mdatain <= '0;
    end else begin
      rej_q <= reject;
      if (accept) begin
        wr_q   <= Write;
        oor_q  <= req_oor;
        addr_q <= MAR_addr[ADDR_W-1:0];
        data_q <= MDR_data;
      end
      if (commit && !c_wr) begin
        Mdatain <= c_oor ? '0 : mem[c_addr];
      end
    end
  end

  // RAM write port; out-of-range stores are dropped.
  always_ff @(posedge clk) begin
    if (!clear && commit && c_wr && !c_oor) begin
      mem[c_addr] <= c_data;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: random + directed bench against a cycle-count model.
// Second instance covers the zero-wait-state configuration.
module tb_memory_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, rd, wr;
  logic [31:0] addr, wdata, mdat;
  logic        busy, done, aerr;

  logic        clear0, rd0, wr0;
  logic [31:0] addr0, wdata0, mdat0;
  logic        busy0, done0, aerr0;

  memory_responder #(
    .ADDR_W(9), .DATA_W(32), .WAIT_STATES(WS), .INIT_FILE("")
  ) dut (
    .clk(clk), .clear(clear), .Read(rd), .Write(wr),
    .MAR_addr(addr), .MDR_data(wdata), .Mdatain(mdat),
    .busy(busy), .done(done), .addr_err(aerr)
  );

  memory_responder #(
    .ADDR_W(9), .DATA_W(32), .WAIT_STATES(0), .INIT_FILE("")
  ) dut0 (
    .clk(clk), .clear(clear0), .Read(rd0), .Write(wr0),
    .MAR_addr(addr0), .MDR_data(wdata0), .Mdatain(mdat0),
    .busy(busy0), .done(done0), .addr_err(aerr0)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Model: a request accepted at edge t responds during the cycle
  // after edge t+WS and frees the port at edge t+WS+1.
  logic [31:0] ram_m [int];
  int          cyc = 0;
  int          resp_at = 0;
  bit          inf = 0;
  bit          m_wr;
  logic [31:0] m_a, m_d;
  logic [31:0] e_mdat = '0;
  bit          e_known = 1;
  bit          e_busy, e_done, e_err;
  bit          chk_on = 0;

  always @(posedge clk) begin : model
    bit was, rej, oor;
    cyc++;
    if (clear) begin
      inf = 0; e_mdat = '0; e_known = 1;
      e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      was = inf;
      rej = 0;
      if (was && cyc == resp_at + 1) inf = 0;
      if (!was) begin
        if (rd && wr) rej = 1;
        else if (rd || wr) begin
          inf = 1; m_wr = wr; m_a = addr; m_d = wdata;
          resp_at = cyc + WS;
        end
      end
      e_done = inf && (cyc == resp_at);
      oor = (m_a[31:9] != 0);
      if (e_done) begin
        if (oor) begin
          if (!m_wr) begin e_mdat = '0; e_known = 1; end
        end else if (m_wr) begin
          ram_m[int'(m_a[8:0])] = m_d;
        end else if (ram_m.exists(int'(m_a[8:0]))) begin
          e_mdat = ram_m[int'(m_a[8:0])]; e_known = 1;
        end else begin
          e_known = 0;
        end
      end
      e_busy = inf;
      e_err = rej || (e_done && oor);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("addr_err", {31'b0, aerr}, {31'b0, e_err});
      if (e_known) chk("Mdatain", mdat, e_mdat);
    end
  end

  task automatic access(input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit meddle,
                        output int lat, output bit err);
    rd = !w; wr = w; addr = a; wdata = d;
    lat = 0; err = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k; err = aerr; rd = 0; wr = 0;
      end else if (meddle) begin
        addr = 32'h1; wdata = 32'h99999999; wr = ~wr;
      end else begin
        rd = 0; wr = 0; addr = $urandom; wdata = $urandom;
      end
    end
    rd = 0; wr = 0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bit err;
    clear = 1; rd = 0; wr = 0; addr = '0; wdata = '0;
    clear0 = 1; rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, aerr}, 32'd0);
    chk("rst_mdat", mdat, 32'd0);
    clear = 0;
    chk_on = 1;

    for (int i = 0; i < 34; i++) begin
      logic [31:0] a;
      a = (i == 32) ? 32'h1FF : (i == 33) ? 32'h0A5 : 32'(i);
      access(1, a, 32'hA000_0000 | a, 0, lat, err);
    end

    access(1, 32'h0A5, 32'h1234ABCD, 0, lat, err);
    chk("wr_latency", 32'(lat), 32'd3);
    access(0, 32'h0A5, 32'h0, 0, lat, err);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_0a5", mdat, 32'h1234ABCD);

    access(1, 32'h000, 32'h00C0FFEE, 0, lat, err);
    access(0, 32'h200, 32'h0, 0, lat, err);
    chk("oor_rd_err", {31'b0, err}, 32'd1);
    chk("oor_rd_data", mdat, 32'd0);
    access(1, 32'h200, 32'hBADBAD00, 0, lat, err);
    chk("oor_wr_err", {31'b0, err}, 32'd1);
    access(0, 32'h000, 32'h0, 0, lat, err);
    chk("oor_wr_noeffect", mdat, 32'h00C0FFEE);

    rd = 1; wr = 1; addr = 32'h000; wdata = 32'h11111111;
    @(negedge clk);
    chk("rej_err", {31'b0, aerr}, 32'd1);
    chk("rej_done", {31'b0, done}, 32'd0);
    chk("rej_busy", {31'b0, busy}, 32'd0);
    rd = 0; wr = 0;
    @(negedge clk);
    chk("rej_err_pulse", {31'b0, aerr}, 32'd0);
    access(0, 32'h000, 32'h0, 0, lat, err);
    chk("rej_old_val", mdat, 32'h00C0FFEE);

    access(1, 32'h003, 32'h33333333, 1, lat, err);
    chk("meddle_latency", 32'(lat), 32'd3);
    access(0, 32'h001, 32'h0, 0, lat, err);
    chk("meddle_no_extra", mdat, 32'hA0000001);
    access(0, 32'h003, 32'h0, 0, lat, err);
    chk("meddle_latched", mdat, 32'h33333333);

    wr = 1; addr = 32'h010; wdata = 32'hDEADBEEF;
    @(negedge clk);
    wr = 0; clear = 1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_err", {31'b0, aerr}, 32'd0);
    chk("midrst_mdat", mdat, 32'd0);
    clear = 0;
    @(negedge clk);
    chk("midrst_nodone", {31'b0, done}, 32'd0);
    access(0, 32'h010, 32'h0, 0, lat, err);
    chk("midrst_prior", mdat, 32'hA0000010);

    for (int i = 0; i < 1500; i++) begin
      int p, q;
      p = $urandom_range(0, 99);
      q = $urandom_range(0, 9);
      rd = (p < 30) || (p >= 60 && p < 65);
      wr = (p >= 30 && p < 65);
      if (q < 8) addr = 32'($urandom_range(0, 31));
      else if (q == 8) addr = 32'h1FF;
      else addr = $urandom | 32'h200;
      wdata = $urandom;
      clear = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    clear = 0; rd = 0; wr = 0;
    repeat (6) @(negedge clk);

    clear0 = 0;
    wr0 = 1; addr0 = 32'h005; wdata0 = 32'hCAFE0005;
    @(negedge clk);
    chk("ws0_wr_done", {31'b0, done0}, 32'd1);
    chk("ws0_wr_busy", {31'b0, busy0}, 32'd1);
    wr0 = 0;
    @(negedge clk);
    chk("ws0_idle_done", {31'b0, done0}, 32'd0);
    chk("ws0_idle_busy", {31'b0, busy0}, 32'd0);
    rd0 = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("ws0_b2b_done", {31'b0, done0}, 32'(k % 2));
      if (k % 2 == 1) chk("ws0_b2b_data", mdat0, 32'hCAFE0005);
    end
    addr0 = 32'h400;
    @(negedge clk);
    chk("ws0_oor_done", {31'b0, done0}, 32'd1);
    chk("ws0_oor_err", {31'b0, aerr0}, 32'd1);
    chk("ws0_oor_data", mdat0, 32'd0);
    rd0 = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
